// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/ack bus transaction per access,
// with lane alignment, store replication, load extension and timeout abort.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNTW    = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] addri,
    input  logic [31:0] memDatai,
    input  logic        memWritei,
    input  logic        memReadi,
    input  logic [1:0]  readModei,
    input  logic        signExti,
    output logic        stall,
    output logic [31:0] loadData,
    output logic        excMisalign,
    output logic        busErr,
    output logic        memReq,
    output logic        memWe,
    output logic [29:0] memAddr,
    output logic [3:0]  memBE,
    output logic [31:0] memWData,
    input  logic [31:0] memRData,
    input  logic        memAck
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNTW-1:0]   r_cnt;
    logic [1:0]        r_lo;
    logic [1:0]        r_mode;
    logic              r_sext;

    logic              w_acc;
    logic              w_aligned;
    logic              w_start;
    logic              w_misalign;
    logic              w_ack;
    logic              w_tmo;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    assign w_acc = memReadi | memWritei;

    // Alignment check, byte enables and lane-replicated store data
    always_comb begin
        case (readModei)
            2'b01: begin
                w_aligned = ~addri[0];
                w_be      = addri[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {memDatai[15:0], memDatai[15:0]};
            end
            2'b10: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << addri[1:0];
                w_wdata   = {4{memDatai[7:0]}};
            end
            default: begin
                w_aligned = (addri[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = memDatai;
            end
        endcase
    end

    // Lane extraction from the bus using the access attributes latched at issue
    always_comb begin
        case (r_lo)
            2'd0:    w_byte = memRData[7:0];
            2'd1:    w_byte = memRData[15:8];
            2'd2:    w_byte = memRData[23:16];
            default: w_byte = memRData[31:24];
        endcase
        w_half = r_lo[1] ? memRData[31:16] : memRData[15:0];
        case (r_mode)
            2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
            2'b10:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            default: w_load = memRData;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_misalign  = 1'b0;
        w_ack       = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc && w_aligned) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end else if (w_acc) begin
                    w_misalign  = 1'b1;
                end
            end
            REQ: begin
                if (memAck) begin
                    w_ack       = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNTW'(TIMEOUT - 1)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset must release the pipeline at once, even with an access still presented
    assign stall = ~RST & (w_start | (r_state == REQ));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= 30'd0;
            memBE       <= 4'd0;
            memWData    <= 32'd0;
            loadData    <= 32'd0;
            excMisalign <= 1'b0;
            busErr      <= 1'b0;
            r_cnt       <= '0;
            r_lo        <= 2'd0;
            r_mode      <= 2'd0;
            r_sext      <= 1'b0;
        end else begin
            excMisalign <= w_misalign;
            busErr      <= w_tmo;
            if (w_start) begin
                memReq   <= 1'b1;
                memWe    <= memWritei;
                memAddr  <= addri[31:2];
                memBE    <= w_be;
                memWData <= w_wdata;
                r_cnt    <= '0;
                r_lo     <= addri[1:0];
                r_mode   <= readModei;
                r_sext   <= signExti;
            end else if (r_state == REQ) begin
                r_cnt <= r_cnt + CNTW'(1);
                if (w_ack || w_tmo) memReq <= 1'b0;
                if (w_ack && !memWe) loadData <= w_load;
                if (w_tmo) loadData <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] addri;
    logic [31:0] memDatai;
    logic        memWritei;
    logic        memReadi;
    logic [1:0]  readModei;
    logic        signExti;
    logic        stall;
    logic [31:0] loadData;
    logic        excMisalign;
    logic        busErr;
    logic        memReq;
    logic        memWe;
    logic [29:0] memAddr;
    logic [3:0]  memBE;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memAck;

    int errors = 0;
    int checks = 0;

    int          n_stall, n_req, fin;
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic [31:0] cap_wdata;

    mem_access_unit #(.TIMEOUT(16), .CNTW(5)) dut (
        .CLK(CLK), .RST(RST), .addri(addri), .memDatai(memDatai),
        .memWritei(memWritei), .memReadi(memReadi), .readModei(readModei),
        .signExti(signExti), .stall(stall), .loadData(loadData),
        .excMisalign(excMisalign), .busErr(busErr), .memReq(memReq),
        .memWe(memWe), .memAddr(memAddr), .memBE(memBE), .memWData(memWData),
        .memRData(memRData), .memAck(memAck)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        memReadi  = 1'b0;
        memWritei = 1'b0;
        addri     = 32'd0;
        memDatai  = 32'd0;
        readModei = 2'b00;
        signExti  = 1'b0;
    endtask

    // Present an access, ack in REQ cycle ack_at (0 = never); returns in DONE with inputs still held
    task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [1:0] mode, input logic sx, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rdat);
        addri = a; memReadi = rd; memWritei = wr; readModei = mode;
        signExti = sx; memDatai = wd;
        n_stall = 0; n_req = 0; fin = 0;
        #1;
        if (stall) n_stall++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            memAck = 1'b0;
            if (k == ack_at) begin
                memAck   = 1'b1;
                memRData = rdat;
            end
            #1;
            if (memReq) n_req++;
            if (k == 1) begin
                cap_addr = memAddr; cap_be = memBE; cap_we = memWe; cap_wdata = memWData;
            end
            if (!stall) begin
                fin = 1;
                break;
            end
            n_stall++;
        end
        memAck = 1'b0;
    endtask

    initial begin
        RST = 1'b1; memAck = 1'b0; memRData = 32'd0;
        clear_inputs();
        repeat (2) tick();
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_memWe", 32'(memWe), 32'd0);
        chk("rst_memAddr", 32'(memAddr), 32'd0);
        chk("rst_memBE", 32'(memBE), 32'd0);
        chk("rst_memWData", memWData, 32'd0);
        chk("rst_loadData", loadData, 32'd0);
        chk("rst_excMisalign", 32'(excMisalign), 32'd0);
        chk("rst_busErr", 32'(busErr), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        RST = 1'b0;
        tick();

        // Word load, ack in third REQ cycle
        access(32'h0000_0010, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 3, 32'hDEAD_BEEF);
        chk("wl_done", 32'(fin), 32'd1);
        chk("wl_stalls", 32'(n_stall), 32'd4);
        chk("wl_addr", 32'(cap_addr), 32'h4);
        chk("wl_be", 32'(cap_be), 32'hF);
        chk("wl_we", 32'(cap_we), 32'd0);
        chk("wl_data", loadData, 32'hDEAD_BEEF);
        chk("wl_req_done", 32'(memReq), 32'd0);
        tick();
        chk("wl_no_reissue", 32'(memReq), 32'd0);
        clear_inputs();
        tick();

        // Byte load at 0x13, signed then unsigned
        access(32'h0000_0013, 1'b1, 1'b0, 2'b10, 1'b1, 32'd0, 1, 32'h8012_3456);
        chk("bl_s_stalls", 32'(n_stall), 32'd2);
        chk("bl_s_be", 32'(cap_be), 32'h8);
        chk("bl_s_data", loadData, 32'hFFFF_FF80);
        tick(); clear_inputs(); tick();
        access(32'h0000_0013, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 1, 32'h8012_3456);
        chk("bl_u_data", loadData, 32'h0000_0080);
        tick(); clear_inputs(); tick();

        // Half store at 0x22 leaves loadData alone
        access(32'h0000_0022, 1'b0, 1'b1, 2'b01, 1'b0, 32'h1234_ABCD, 2, 32'h5555_5555);
        chk("hs_we", 32'(cap_we), 32'd1);
        chk("hs_be", 32'(cap_be), 32'hC);
        chk("hs_wdata", cap_wdata, 32'hABCD_ABCD);
        chk("hs_addr", 32'(cap_addr), 32'h8);
        chk("hs_stalls", 32'(n_stall), 32'd3);
        chk("hs_load_kept", loadData, 32'h0000_0080);
        tick(); clear_inputs(); tick();

        // Signed half load from low lane, unsigned byte from lane 1, both-set store wins
        access(32'h0000_0000, 1'b1, 1'b0, 2'b01, 1'b1, 32'd0, 1, 32'h8001_F00F);
        chk("hl_be", 32'(cap_be), 32'h3);
        chk("hl_data", loadData, 32'hFFFF_F00F);
        tick(); clear_inputs(); tick();
        access(32'h0000_0101, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 1, 32'h0000_AB00);
        chk("b1_be", 32'(cap_be), 32'h2);
        chk("b1_data", loadData, 32'h0000_00AB);
        tick(); clear_inputs(); tick();
        access(32'h0000_0104, 1'b1, 1'b1, 2'b11, 1'b0, 32'hCAFE_0001, 1, 32'h7777_7777);
        chk("rw_we", 32'(cap_we), 32'd1);
        chk("rw_be", 32'(cap_be), 32'hF);
        chk("rw_wdata", cap_wdata, 32'hCAFE_0001);
        chk("rw_load_kept", loadData, 32'h0000_00AB);
        tick(); clear_inputs(); tick();

        // Misaligned word load at 0x6
        addri = 32'h0000_0006; memReadi = 1'b1; readModei = 2'b00;
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        tick();
        chk("mis_exc", 32'(excMisalign), 32'd1);
        chk("mis_req", 32'(memReq), 32'd0);
        chk("mis_stall2", 32'(stall), 32'd0);
        clear_inputs();
        tick();
        chk("mis_exc_pulse", 32'(excMisalign), 32'd0);
        chk("mis_req2", 32'(memReq), 32'd0);

        // Timeout with no ack
        access(32'h0000_0040, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 0, 32'd0);
        chk("to_done", 32'(fin), 32'd1);
        chk("to_req_cycles", 32'(n_req), 32'd16);
        chk("to_stalls", 32'(n_stall), 32'd17);
        chk("to_busErr", 32'(busErr), 32'd1);
        chk("to_load", loadData, 32'd0);
        chk("to_req_off", 32'(memReq), 32'd0);
        clear_inputs();
        tick();
        chk("to_busErr_pulse", 32'(busErr), 32'd0);
        chk("to_idle_stall", 32'(stall), 32'd0);

        // Stray ack while idle
        memAck = 1'b1; memRData = 32'hFFFF_FFFF;
        tick();
        memAck = 1'b0;
        tick();
        chk("idle_ack_ignored", loadData, 32'd0);

        // Reset in second REQ cycle, then a late ack
        access(32'h0000_0000, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0, 1, 32'h1111_1111);
        chk("pre_rst_load", loadData, 32'h1111_1111);
        tick(); clear_inputs(); tick();
        addri = 32'h0000_0020; memReadi = 1'b1; readModei = 2'b00;
        tick();
        chk("rr_req1", 32'(memReq), 32'd1);
        tick();
        RST = 1'b1;
        #1;
        chk("rr_req_drop", 32'(memReq), 32'd0);
        chk("rr_stall_drop", 32'(stall), 32'd0);
        chk("rr_load", loadData, 32'd0);
        clear_inputs();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        memAck = 1'b1; memRData = 32'hCAFE_CAFE;
        tick();
        memAck = 1'b0;
        #1;
        chk("rr_late_ack_load", loadData, 32'd0);
        chk("rr_late_ack_req", 32'(memReq), 32'd0);
        chk("rr_late_ack_stall", 32'(stall), 32'd0);
        tick();
        chk("rr_final_load", loadData, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine that sits between the EX/MEM pipeline register outputs and the data-memory bus.
- Takes the registered address (ALU result), store data, write enable and access size. Runs one request/acknowledge transaction per access on the data bus.
- Returns size-aligned, extended load data to the MEM/WB register.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for memAck before aborting (>=2).
- CNTW, 5, width of the timeout counter (2^CNTW > TIMEOUT).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- addri  input  32  byte address (ALU result from EX/MEM).
- memDatai  input  32  store data from EX/MEM.
- memWritei  input  1  store request.
- memReadi  input  1  load request (decoded from whatToReg selecting memory).
- readModei  input  2  access size: 00 word, 01 halfword, 10 byte, 11 treated as word.
- signExti  input  1  1 = sign-extend loads, 0 = zero-extend.
- stall  output  1  freeze all pipeline registers upstream of MEM/WB.
- loadData  output  32  extended load result; registered.
- excMisalign  output  1  one-cycle pulse on a misaligned access.
- busErr  output  1  one-cycle pulse on a timeout abort.
- memReq  output  1  bus request; registered.
- memWe  output  1  bus write enable; registered.
- memAddr  output  30  word address (addr[31:2]); registered.
- memBE  output  4  byte enables; registered.
- memWData  output  32  lane-replicated store data; registered.
- memRData  input  32  bus read data; valid when memAck=1.
- memAck  input  1  bus acknowledge; one cycle per request.

Behaviour:
- Reset (asynchronous, immediate) drives:
  - state = IDLE
  - memReq = 0, memWe = 0, memAddr = 0, memBE = 0, memWData = 0
  - loadData = 0, excMisalign = 0, busErr = 0, counter = 0
- Reset mid-transaction: the transaction is abandoned and memReq drops at once. A late memAck after reset is ignored.
- Access valid: acc = memReadi | memWritei. If both are set, the store wins and memWe = 1.
- Alignment:
  - word needs addr[1:0] = 00
  - half needs addr[0] = 0
  - byte is always aligned
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- Store data replication:
  - word: as is
  - half: {d[15:0], d[15:0]}
  - byte: {4{d[7:0]}}
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - acc and aligned: latch bus outputs, set memReq = 1, clear counter, go to REQ.
  - acc and misaligned: pulse excMisalign next cycle, issue no bus request, stay in IDLE.
  - no acc: stay in IDLE.
- REQ:
  - memReq is held and bus outputs are stable; counter increments each cycle.
  - memAck = 1: memReq goes to 0. If a load, loadData captures the extracted lane of memRData. Go to DONE.
  - counter reaches TIMEOUT-1 with no ack: memReq goes to 0, pulse busErr, loadData = 0, go to DONE.
- DONE: one cycle with stall = 0 so the pipeline advances, then return to IDLE unconditionally. Inputs present in DONE are never re-issued.
- Stall is combinational: stall = (IDLE & acc & aligned) | REQ.
  - Stall is 0 in DONE and for misaligned or no-access cycles.
- Load extraction:
  - byte lane = addr[1:0]
  - half lane = addr[1]
  - sign bit taken from the selected lane MSB when signExti = 1
- Stores leave loadData unchanged.
- Latency:
  - aligned access with ack in the first REQ cycle: 2 stall cycles (IDLE-detect, REQ), loadData valid in DONE.
  - each extra wait cycle adds 1 stall cycle.
- memAck outside REQ is ignored.

Test Plan:
- Word load at 0x0000_0010, ack after 3 REQ cycles, memRData = 0xDEAD_BEEF:
  - memAddr = 0x4, memBE = 1111, memWe = 0
  - stall high for 4 cycles
  - loadData = 0xDEAD_BEEF in DONE
- Byte load at 0x13 with memRData = 0x80xx_xxxx:
  - signExti = 1 gives loadData = 0xFFFF_FF80
  - signExti = 0 gives loadData = 0x0000_0080
  - memBE = 1000
- Half store at 0x22, memDatai = 0x1234_ABCD:
  - memWe = 1, memBE = 1100, memWData = 0xABCD_ABCD, memAddr = 0x8
  - loadData unchanged
- Word load at 0x0000_0006:
  - excMisalign pulses for one cycle
  - stall never asserts
  - memReq stays 0
- Load with memAck never asserted, TIMEOUT = 16:
  - memReq high exactly 16 cycles, then busErr pulses
  - loadData = 0, DONE, then IDLE
- RST asserted in the 2nd REQ cycle:
  - memReq = 0 and stall = 0 immediately
  - a memAck one cycle later is ignored
  - loadData = 0
